// File: rtl/mem_wb_stage_pkg.sv
// Shared defines for the MEM->WB stage: control levels, load-type codes and bus widths.
package mem_wb_stage_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LBU  = 3'd2;
  localparam logic [2:0] LT_LH   = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LW   = 3'd5;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load extraction: big-endian lane select plus sign/zero extension.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]           load_type,
  input  logic [1:0]           addr_lo,
  input  logic [DataWidth-1:0] rdata,
  input  logic [DataWidth-1:0] alu_data,
  output logic [DataWidth-1:0] data,
  output logic                 we_ok
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane 0 is the most significant byte.
  always_comb begin
    unique case (addr_lo)
      2'd0:    lane_byte = rdata[31:24];
      2'd1:    lane_byte = rdata[23:16];
      2'd2:    lane_byte = rdata[15:8];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    data  = ZeroWord;
    we_ok = 1'b1;
    case (load_type)
      LT_NONE: data = alu_data;
      LT_LB:   data = {{24{lane_byte[7]}}, lane_byte};
      LT_LBU:  data = {24'h0, lane_byte};
      LT_LH:   data = {{16{lane_half[15]}}, lane_half};
      LT_LHU:  data = {16'h0, lane_half};
      LT_LW:   data = rdata;
      default: begin
        data  = ZeroWord;
        we_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register feeding the regfile write port, plus the HI/LO registers.
// Optional WB_HILO_BYPASS_EN forwards the pending HI/LO write onto hi_o/lo_o.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_hilo_we,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic              wb_hilo_we_q, wb_hilo_we_d;
  logic [DATA_W-1:0] wb_hi_q, wb_hi_d;
  logic [DATA_W-1:0] wb_lo_q, wb_lo_d;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic [DATA_W-1:0] align_data;
  logic              align_we_ok;

  load_align u_load_align (
    .load_type (mem_load_type),
    .addr_lo   (mem_addr_lo),
    .rdata     (mem_rdata),
    .alu_data  (mem_wdata),
    .data      (align_data),
    .we_ok     (align_we_ok)
  );

  always_comb begin
    wb_we_d      = wb_we_q;
    wb_waddr_d   = wb_waddr_q;
    wb_wdata_d   = wb_wdata_q;
    wb_hilo_we_d = wb_hilo_we_q;
    wb_hi_d      = wb_hi_q;
    wb_lo_d      = wb_lo_q;
    if (flush || (stall_mem && !stall_wb)) begin
      wb_we_d      = 1'b0;
      wb_waddr_d   = '0;
      wb_wdata_d   = ZeroWord;
      wb_hilo_we_d = 1'b0;
      wb_hi_d      = ZeroWord;
      wb_lo_d      = ZeroWord;
    end else if (stall_wb) begin
      // A held HI/LO writer commits on this edge; clearing keeps it to one commit.
      wb_hilo_we_d = 1'b0;
    end else begin
      wb_we_d      = mem_we & align_we_ok;
      wb_waddr_d   = mem_waddr;
      wb_wdata_d   = align_data;
      wb_hilo_we_d = mem_hilo_we;
      wb_hi_d      = mem_hi;
      wb_lo_d      = mem_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= ZeroWord;
      wb_hilo_we_q <= 1'b0;
      wb_hi_q      <= ZeroWord;
      wb_lo_q      <= ZeroWord;
      hi_q         <= ZeroWord;
      lo_q         <= ZeroWord;
    end else begin
      wb_we_q      <= wb_we_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      wb_hilo_we_q <= wb_hilo_we_d;
      wb_hi_q      <= wb_hi_d;
      wb_lo_q      <= wb_lo_d;
      if (wb_hilo_we_q == WriteEnable) begin
        hi_q <= wb_hi_q;
        lo_q <= wb_lo_q;
      end
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
`ifdef WB_HILO_BYPASS_EN
    if (wb_hilo_we_q) begin
      hi_o = wb_hi_q;
      lo_o = wb_lo_q;
    end
`endif
    if (rst == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a random run against a
// transaction-level model of the WB entry and the architectural HI/LO values.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_load_type = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_hilo_we = 1'b0;
  logic [31:0] mem_hi = '0;
  logic [31:0] mem_lo = '0;
  logic        stall_mem = 1'b0;
  logic        stall_wb = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the instruction sitting in WB and the architectural HI/LO.
  logic        m_we = 1'b0, m_hwe = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0, m_hi = '0, m_lo = '0, m_arch_hi = '0, m_arch_lo = '0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_load_type (mem_load_type),
    .mem_addr_lo   (mem_addr_lo),
    .mem_rdata     (mem_rdata),
    .mem_hilo_we   (mem_hilo_we),
    .mem_hi        (mem_hi),
    .mem_lo        (mem_lo),
    .stall_mem     (stall_mem),
    .stall_wb      (stall_wb),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  // Returns {write_allowed, data} from plain shift/mask arithmetic.
  function automatic logic [32:0] ref_load(input logic [2:0] lt, input logic [1:0] a,
                                           input logic [31:0] rd, input logic [31:0] alu);
    logic [31:0] v;
    int unsigned sh;
    case (lt)
      3'd0: return {1'b1, alu};
      3'd1, 3'd2: begin
        sh = 8 * (3 - int'(a));
        v  = (rd >> sh) & 32'hFF;
        if (lt == 3'd1 && v > 32'd127) v = v - 32'h100;
        return {1'b1, v};
      end
      3'd3, 3'd4: begin
        v = a[1] ? (rd & 32'hFFFF) : (rd >> 16);
        if (lt == 3'd3 && v > 32'd32767) v = v - 32'h1_0000;
        return {1'b1, v};
      end
      3'd5: return {1'b1, rd};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
`ifdef WB_HILO_BYPASS_EN
    if (m_hwe) return m_hi;
`endif
    return m_arch_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
`ifdef WB_HILO_BYPASS_EN
    if (m_hwe) return m_lo;
`endif
    return m_arch_lo;
  endfunction

  task automatic model_step();
    logic [32:0] r;
    if (rst) begin
      m_we = 0; m_waddr = 0; m_wdata = 0; m_hwe = 0; m_hi = 0; m_lo = 0;
      m_arch_hi = 0; m_arch_lo = 0;
    end else begin
      if (m_hwe) begin
        m_arch_hi = m_hi;
        m_arch_lo = m_lo;
      end
      if (flush || (stall_mem && !stall_wb)) begin
        m_we = 0; m_waddr = 0; m_wdata = 0; m_hwe = 0;
      end else if (stall_wb) begin
        m_hwe = 0;  // held entry already committed once
      end else begin
        r       = ref_load(mem_load_type, mem_addr_lo, mem_rdata, mem_wdata);
        m_we    = mem_we && r[32];
        m_waddr = mem_waddr;
        m_wdata = r[31:0];
        m_hwe   = mem_hilo_we;
        m_hi    = mem_hi;
        m_lo    = mem_lo;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    mem_we = 0; mem_waddr = 0; mem_wdata = 0; mem_load_type = 0; mem_addr_lo = 0;
    mem_rdata = 0; mem_hilo_we = 0; mem_hi = 0; mem_lo = 0;
    stall_mem = 0; stall_wb = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    n_checks++;
    if (wb_we !== 1'b0 || wb_wdata !== 32'h0 || wb_waddr !== 5'h0) begin
      n_errors++;
      $display("FAIL reset_wb: we=%b waddr=%h wdata=%h required 0/0/0", wb_we, wb_waddr, wb_wdata);
    end
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi_o, lo_o);
    end
    rst = 0;
    mem_we = 1; mem_waddr = 5'd3; mem_wdata = 32'h1234;
    tick();
    n_checks++;
    if (wb_we !== 1'b1 || wb_waddr !== 5'd3 || wb_wdata !== 32'h0000_1234) begin
      n_errors++;
      $display("FAIL first_capture: we=%b waddr=%0d wdata=%h required 1/3/00001234",
               wb_we, wb_waddr, wb_wdata);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [1:0]  al  [6] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_7F01, 32'h0000_80FF,
                             32'h80FF_7F01, 32'h0};
    logic        ewe [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_we = 1; mem_waddr = 5'(i + 1); mem_wdata = 32'hDEAD_BEEF;
      mem_rdata = 32'h80FF_7F01; mem_load_type = lt[i]; mem_addr_lo = al[i];
      tick();
      n_checks++;
      if (wb_wdata !== exp[i] || wb_we !== ewe[i]) begin
        n_errors++;
        $display("FAIL load_type%0d: wdata=%h we=%b required %h/%b",
                 lt[i], wb_wdata, wb_we, exp[i], ewe[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    mem_we = 1; mem_waddr = 5'd9; mem_wdata = 32'hCAFE_0001;
    tick();
    mem_waddr = 5'd10; mem_wdata = 32'h1111_2222; stall_wb = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wb_we !== 1'b1 || wb_waddr !== 5'd9 || wb_wdata !== 32'hCAFE_0001) begin
        n_errors++;
        $display("FAIL stall_hold%0d: we=%b waddr=%0d wdata=%h required 1/9/cafe0001",
                 i, wb_we, wb_waddr, wb_wdata);
      end
    end
    stall_wb = 0; stall_mem = 1;
    tick();
    n_checks++;
    if (wb_we !== 1'b0 || wb_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL stall_mem_bubble: we=%b wdata=%h required 0/0", wb_we, wb_wdata);
    end
    stall_mem = 0;
    tick();
    stall_wb = 1; flush = 1;
    tick();
    n_checks++;
    if (wb_we !== 1'b0 || wb_waddr !== 5'd0 || wb_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL flush_over_stall: we=%b waddr=%0d wdata=%h required 0/0/0",
               wb_we, wb_waddr, wb_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_hilo();
    logic [31:0] exp_in_wb;
`ifdef WB_HILO_BYPASS_EN
    exp_in_wb = 32'hAAAA_0000;
`else
    exp_in_wb = 32'h0;
`endif
    do_reset();
    mem_hilo_we = 1; mem_hi = 32'hAAAA_0000; mem_lo = 32'h5555;
    tick();
    n_checks++;
    if (hi_o !== exp_in_wb) begin
      n_errors++;
      $display("FAIL hilo_in_wb: hi_o=%h required %h", hi_o, exp_in_wb);
    end
    mem_hilo_we = 0; mem_hi = 0; mem_lo = 0;
    tick();
    n_checks++;
    if (hi_o !== 32'hAAAA_0000 || lo_o !== 32'h5555) begin
      n_errors++;
      $display("FAIL hilo_commit: hi=%h lo=%h required aaaa0000/00005555", hi_o, lo_o);
    end
  endtask

  task automatic test_stalled_hilo();
    do_reset();
    mem_hilo_we = 1; mem_hi = 32'h5; mem_lo = 32'h6;
    tick();
    mem_hi = 32'h1; mem_lo = 32'h2; stall_wb = 1;
    tick();
    tick();
    n_checks++;
    if (hi_o !== 32'h5 || lo_o !== 32'h6) begin
      n_errors++;
      $display("FAIL stalled_hilo_once: hi=%h lo=%h required 5/6", hi_o, lo_o);
    end
    stall_wb = 0;
    tick();
    mem_hilo_we = 0;
    tick();
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
      n_errors++;
      $display("FAIL younger_hilo_wins: hi=%h lo=%h required 1/2", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_we = 1; mem_waddr = 5'd7; mem_hilo_we = 1; mem_hi = 32'h77; mem_lo = 32'h88;
    tick();
    stall_wb = 1; rst = 1;
    tick();
    n_checks++;
    if (wb_we !== 1'b0 || hi_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_stall: we=%b hi=%h required 0/0", wb_we, hi_o);
    end
    rst = 0; stall_wb = 0; stall_mem = 1;
    tick();
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_no_commit: hi=%h lo=%h required 0/0", hi_o, lo_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      stall_wb      = ($urandom_range(0, 4) == 0);
      stall_mem     = ($urandom_range(0, 7) == 0);
      mem_we        = 1'($urandom);
      mem_waddr     = 5'($urandom);
      mem_wdata     = $urandom;
      mem_load_type = 3'($urandom);
      mem_addr_lo   = 2'($urandom);
      mem_rdata     = $urandom;
      mem_hilo_we   = ($urandom_range(0, 2) == 0);
      mem_hi        = $urandom;
      mem_lo        = $urandom;
      tick();
      n_checks++;
      if (wb_we !== m_we || wb_waddr !== m_waddr || wb_wdata !== m_wdata) begin
        n_errors++;
        $display("FAIL rand_wb[%0d]: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                 i, wb_we, wb_waddr, wb_wdata, m_we, m_waddr, m_wdata);
      end
      n_checks++;
      if (hi_o !== exp_hi() || lo_o !== exp_lo()) begin
        n_errors++;
        $display("FAIL rand_hilo[%0d]: hi=%h lo=%h required %h/%h",
                 i, hi_o, lo_o, exp_hi(), exp_lo());
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_stall_flush();
    test_hilo();
    test_stalled_hilo();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
